mem_access_stage: RTL

MEM pipeline stage plus MEM/WB pipeline register: consumes the EX/MEM register outputs, performs the load/store through a request/acknowledge data-memory port, resolves the branch, and registers results for write-back. It sits between the EX/MEM register and the write-back mux. When a memory access is pending, it asserts `mem_stall` to freeze IF through EX.

---
 rtl/mem_access_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage with MEM/WB register: drives a req/ack data-memory port, resolves
// branches, stalls upstream while an access is outstanding and aborts it after TIMEOUT cycles.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] EX_MEM_PC,
  input  logic        EX_MEM_mem_to_reg,
  input  logic        EX_MEM_reg_write,
  input  logic        EX_MEM_mem_read,
  input  logic        EX_MEM_mem_write,
  input  logic        EX_MEM_branch,
  input  logic        EX_MEM_zero,
  input  logic [4:0]  EX_MEM_rt,
  input  logic [31:0] EX_MEM_data_out2,
  input  logic [31:0] EX_MEM_ALU,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        mem_stall,
  output logic        MEM_WB_mem_to_reg,
  output logic        MEM_WB_reg_write,
  output logic [4:0]  MEM_WB_rt,
  output logic [31:0] MEM_WB_read_data,
  output logic [31:0] MEM_WB_ALU,
  output logic        mem_error
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_to_reg_q, mem_to_reg_d;
  logic            reg_write_q, reg_write_d;
  logic [4:0]      rt_q, rt_d;
  logic [31:0]     read_data_q, read_data_d;
  logic [31:0]     alu_q, alu_d;
  logic            mem_error_q, mem_error_d;

  logic        op;
  logic        capture;
  logic [31:0] rdata_sel;

  assign op            = EX_MEM_mem_read | EX_MEM_mem_write;
  assign pc_src        = EX_MEM_branch & EX_MEM_zero;
  assign branch_target = EX_MEM_PC;
  assign dmem_req      = (state_q == StWait);
  assign dmem_we       = EX_MEM_mem_write;
  assign dmem_addr     = EX_MEM_ALU;
  assign dmem_wdata    = EX_MEM_data_out2;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    rdata_sel   = '0;
    mem_error_d = mem_error_q;
    mem_stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op) begin
          mem_stall = 1'b1;
          state_d   = StWait;
          cnt_d     = '0;
        end else begin
          capture = 1'b1;
        end
      end
      StWait: begin
        if (dmem_ack) begin
          capture   = 1'b1;
          // A combined read+write is treated as a write: no data returned.
          rdata_sel = EX_MEM_mem_write ? 32'h0 : dmem_rdata;
          state_d   = StIdle;
        end else if (cnt_q == CntLast) begin
          capture     = 1'b1;
          mem_error_d = 1'b1;
          state_d     = StIdle;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Anything not captured is a bubble, fully zeroed.
    mem_to_reg_d = capture ? EX_MEM_mem_to_reg : 1'b0;
    reg_write_d  = capture ? EX_MEM_reg_write : 1'b0;
    rt_d         = capture ? EX_MEM_rt : 5'd0;
    alu_d        = capture ? EX_MEM_ALU : 32'h0;
    read_data_d  = rdata_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      rt_q         <= 5'd0;
      read_data_q  <= 32'h0;
      alu_q        <= 32'h0;
      mem_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      rt_q         <= rt_d;
      read_data_q  <= read_data_d;
      alu_q        <= alu_d;
      mem_error_q  <= mem_error_d;
    end
  end

  assign MEM_WB_mem_to_reg = mem_to_reg_q;
  assign MEM_WB_reg_write  = reg_write_q;
  assign MEM_WB_rt         = rt_q;
  assign MEM_WB_read_data  = read_data_q;
  assign MEM_WB_ALU        = alu_q;
  assign mem_error         = mem_error_q;

endmodule
